// File: rtl/exc_commit_pkg.sv
// Shared constants for the commit-point exception controller: ExcCodes, m_exc bit
// positions, the Status.Bev index, FSM states and the priority-encoder result record.
package exc_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // m_exc = {ades, adel_ld, brk, sys, ov, ri, adel_if}
  localparam int MEXC_ADEL_IF = 0;
  localparam int MEXC_RI      = 1;
  localparam int MEXC_OV      = 2;
  localparam int MEXC_SYS     = 3;
  localparam int MEXC_BRK     = 4;
  localparam int MEXC_ADEL_LD = 5;
  localparam int MEXC_ADES    = 6;

  localparam int STATUS_BEV = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] excode;
    logic       is_eret;
    logic       is_addr_if;
    logic       is_addr_data;
  } prio_t;

  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_commit_prio.sv
// Combinational cause selector: picks the single highest-priority cause among the
// interrupt, the per-stage exception flags and ERET.
module exc_commit_prio
  import exc_commit_pkg::*;
(
  input  logic       int_req,
  input  logic [6:0] m_exc,
  input  logic       m_eret,
  output prio_t      prio_o
);

  always_comb begin
    prio_o = '0;
    if (int_req) begin
      prio_o.hit    = 1'b1;
      prio_o.excode = EXC_INT;
    end else if (m_exc[MEXC_ADEL_IF]) begin
      prio_o.hit        = 1'b1;
      prio_o.excode     = EXC_ADEL;
      prio_o.is_addr_if = 1'b1;
    end else if (m_exc[MEXC_RI]) begin
      prio_o.hit    = 1'b1;
      prio_o.excode = EXC_RI;
    end else if (m_exc[MEXC_OV]) begin
      prio_o.hit    = 1'b1;
      prio_o.excode = EXC_OV;
    end else if (m_exc[MEXC_SYS]) begin
      prio_o.hit    = 1'b1;
      prio_o.excode = EXC_SYS;
    end else if (m_exc[MEXC_BRK]) begin
      prio_o.hit    = 1'b1;
      prio_o.excode = EXC_BP;
    end else if (m_exc[MEXC_ADEL_LD]) begin
      prio_o.hit          = 1'b1;
      prio_o.excode       = EXC_ADEL;
      prio_o.is_addr_data = 1'b1;
    end else if (m_exc[MEXC_ADES]) begin
      prio_o.hit          = 1'b1;
      prio_o.excode       = EXC_ADES;
      prio_o.is_addr_data = 1'b1;
    end else if (m_eret) begin
      // ERET only wins when nothing else is pending; its ExcCode field stays 0.
      prio_o.hit     = 1'b1;
      prio_o.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// Commit-point exception/interrupt controller: strobes CP0, flushes the pipeline,
// waits for the data bus to drain, then hands a held redirect PC to fetch.
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter logic [31:0] VEC_BEV    = 32'hBFC00380,
  parameter logic [31:0] VEC_NORMAL = 32'h80000180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [6:0]  m_exc,
  input  logic        m_eret,
  input  logic [31:0] m_badvaddr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  input  logic        int_req,
  input  logic        mem_outstanding,
  input  logic        redirect_ready,
  output logic        exc_valid,
  output logic [4:0]  exc_excode,
  output logic        exc_bd,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_badvaddr,
  output logic        exc_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  prio_t       prio;
  logic        event_hit;
  logic [31:0] vector;

  logic unused_status;
  assign unused_status = ^{cp0_status[31:STATUS_BEV+1], cp0_status[STATUS_BEV-1:0]};

  exc_commit_prio u_prio (
    .int_req (int_req),
    .m_exc   (m_exc),
    .m_eret  (m_eret),
    .prio_o  (prio)
  );

  assign event_hit = m_valid && prio.hit;
  assign vector    = cp0_status[STATUS_BEV] ? VEC_BEV : VEC_NORMAL;

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    exc_valid      = 1'b0;
    exc_excode     = 5'd0;
    exc_bd         = 1'b0;
    exc_epc        = 32'd0;
    exc_badvaddr   = 32'd0;
    exc_eret       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (event_hit) begin
          exc_valid  = 1'b1;
          flush      = 1'b1;
          exc_excode = prio.excode;
          exc_bd     = m_bd;
          exc_epc    = epc_of(m_pc, m_bd);
          exc_eret   = prio.is_eret;
          if (prio.is_addr_if) begin
            exc_badvaddr = m_pc;
          end else if (prio.is_addr_data) begin
            exc_badvaddr = m_badvaddr;
          end
          target_d = prio.is_eret ? cp0_epc : vector;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (!mem_outstanding) begin
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        // target_q only changes in IDLE, so the redirect stays stable until accepted.
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Bench for exc_commit: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level model of the commit/drain/redirect sequence.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [6:0]  m_exc;
  logic        m_eret;
  logic [31:0] m_badvaddr;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        int_req;
  logic        mem_outstanding;
  logic        redirect_ready;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an exception is "in progress" until fetch accepts its redirect;
  // "drained" once the bus had nothing outstanding after the event.
  bit          mdl_busy;
  bit          mdl_drained;
  logic [31:0] mdl_target;

  always #5 clk = ~clk;

  exc_commit dut (
    .clk             (clk),
    .reset           (reset),
    .m_valid         (m_valid),
    .m_pc            (m_pc),
    .m_bd            (m_bd),
    .m_exc           (m_exc),
    .m_eret          (m_eret),
    .m_badvaddr      (m_badvaddr),
    .cp0_status      (cp0_status),
    .cp0_epc         (cp0_epc),
    .int_req         (int_req),
    .mem_outstanding (mem_outstanding),
    .redirect_ready  (redirect_ready),
    .exc_valid       (exc_valid),
    .exc_excode      (exc_excode),
    .exc_bd          (exc_bd),
    .exc_epc         (exc_epc),
    .exc_badvaddr    (exc_badvaddr),
    .exc_eret        (exc_eret),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cause ranking: Int first, then m_exc bits in ascending index order, then ERET.
  task automatic ref_cause(output bit hit, output logic [4:0] code, output bit is_er,
                           output logic [31:0] badv);
    logic [4:0] code_tab [7] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    hit = 0; code = 5'd0; is_er = 0; badv = 32'd0;
    if (int_req) begin
      hit = 1;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!hit && m_exc[i]) begin
          hit  = 1;
          code = code_tab[i];
          badv = (i == 0) ? m_pc : ((i >= 5) ? m_badvaddr : 32'd0);
        end
      end
      if (!hit && m_eret) begin
        hit   = 1;
        is_er = 1;
      end
    end
  endtask

  task automatic check_model();
    bit hit, is_er, ev;
    logic [4:0]  code;
    logic [31:0] badv;
    logic e_valid, e_bd, e_eret, e_flush, e_rv;
    logic [4:0]  e_code;
    logic [31:0] e_epc, e_badv, e_rpc;
    ref_cause(hit, code, is_er, badv);
    ev = !mdl_busy && m_valid && hit;
    e_valid = 0; e_bd = 0; e_eret = 0; e_flush = 0; e_rv = 0;
    e_code = 0; e_epc = 0; e_badv = 0; e_rpc = 0;
    if (ev) begin
      e_valid = 1; e_flush = 1; e_code = code; e_bd = m_bd; e_eret = is_er;
      e_epc = m_bd ? m_pc - 32'd4 : m_pc;
      e_badv = badv;
    end else if (mdl_busy) begin
      e_flush = 1;
      if (mdl_drained) begin
        e_rv = 1;
        e_rpc = mdl_target;
      end
    end
    chk("exc_valid", exc_valid, e_valid);
    chk("exc_excode", exc_excode, e_code);
    chk("exc_bd", exc_bd, e_bd);
    chk("exc_epc", exc_epc, e_epc);
    chk("exc_badvaddr", exc_badvaddr, e_badv);
    chk("exc_eret", exc_eret, e_eret);
    chk("flush", flush, e_flush);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    bit hit, is_er, ev;
    logic [4:0]  code;
    logic [31:0] badv;
    ref_cause(hit, code, is_er, badv);
    ev = !mdl_busy && m_valid && hit;
    @(posedge clk);
    if (reset) begin
      mdl_busy = 0; mdl_drained = 0; mdl_target = 32'd0;
    end else if (ev) begin
      mdl_busy = 1; mdl_drained = 0;
      mdl_target = is_er ? cp0_epc : (cp0_status[22] ? 32'hBFC00380 : 32'h80000180);
    end else if (mdl_busy && !mdl_drained) begin
      if (!mem_outstanding) mdl_drained = 1;
    end else if (mdl_busy && mdl_drained && redirect_ready) begin
      mdl_busy = 0; mdl_drained = 0;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic quiet();
    m_valid = 0; m_exc = 7'd0; m_eret = 0; int_req = 0; m_bd = 0;
  endtask

  initial begin
    mdl_busy = 0; mdl_drained = 0; mdl_target = 32'd0;
    reset = 1; quiet();
    m_pc = 32'd0; m_badvaddr = 32'd0; cp0_status = 32'd0; cp0_epc = 32'd0;
    mem_outstanding = 0; redirect_ready = 1;
    tick(); tick();
    reset = 0;
    cyc();

    // Syscall, Bev=1
    cp0_status = 32'h0040_0000;
    m_valid = 1; m_pc = 32'hBFC00100; m_exc = 7'b000_1000;
    settle();
    chk("t2_code", exc_excode, 32'h08);
    chk("t2_epc", exc_epc, 32'hBFC00100);
    tick(); quiet();
    cyc();
    settle();
    chk("t2_rpc", redirect_pc, 32'hBFC00380);
    tick();
    cyc();

    // AdEL_ld in a delay slot, Bev=0
    cp0_status = 32'd0;
    m_valid = 1; m_bd = 1; m_pc = 32'h80001004; m_badvaddr = 32'h3; m_exc = 7'b010_0000;
    settle();
    chk("t3_code", exc_excode, 32'h04);
    chk("t3_bd", exc_bd, 32'h1);
    chk("t3_epc", exc_epc, 32'h80001000);
    chk("t3_badv", exc_badvaddr, 32'h3);
    tick(); quiet();
    cyc();
    settle();
    chk("t3_rpc", redirect_pc, 32'h80000180);
    tick();

    // Interrupt waits for a committing instruction, then beats RI
    int_req = 1;
    repeat (4) begin
      settle();
      chk("t4_noact", {exc_valid, flush}, 32'h0);
      tick();
    end
    m_valid = 1; m_exc = 7'b000_0010;
    settle();
    chk("t4_code", exc_excode, 32'h00);
    chk("t4_valid", exc_valid, 32'h1);
    tick(); quiet();
    cyc(); cyc();

    // ERET with a slow bus drain
    cp0_epc = 32'hBFC00abc; cp0_status = 32'h0040_0000;
    mem_outstanding = 1;
    m_valid = 1; m_eret = 1;
    settle();
    chk("t5_eret", exc_eret, 32'h1);
    tick(); quiet();
    repeat (5) begin
      settle();
      chk("t5_drain", {flush, redirect_valid}, 32'h2);
      tick();
    end
    mem_outstanding = 0;
    cyc();
    settle();
    chk("t5_rpc", redirect_pc, 32'hBFC00abc);
    tick();
    m_valid = 1; m_eret = 1; m_exc = 7'b000_0100;
    settle();
    chk("t5_ov_code", exc_excode, 32'h0c);
    chk("t5_ov_eret", exc_eret, 32'h0);
    tick(); quiet();
    cyc(); cyc();

    // Redirect back-pressure with stray events
    redirect_ready = 0;
    m_valid = 1; m_exc = 7'b001_0000;
    cyc(); quiet();
    cyc();
    m_valid = 1; m_exc = 7'b000_1000;
    repeat (3) begin
      settle();
      chk("t6_rv", redirect_valid, 32'h1);
      chk("t6_rpc", redirect_pc, 32'hBFC00380);
      chk("t6_novalid", exc_valid, 32'h0);
      tick();
    end
    quiet(); redirect_ready = 1;
    cyc(); cyc();

    // Reset while a redirect is pending
    redirect_ready = 0;
    m_valid = 1; m_exc = 7'b000_1000;
    cyc(); quiet();
    cyc();
    reset = 1;
    repeat (3) cyc();
    reset = 0;
    settle();
    chk("t1_idle", {exc_valid, flush, redirect_valid}, 32'h0);
    tick();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      m_valid         = ($urandom_range(0, 2) == 0);
      m_pc            = $urandom;
      m_bd            = $urandom_range(0, 1);
      m_badvaddr      = $urandom;
      m_eret          = ($urandom_range(0, 5) == 0);
      int_req         = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 7; b++) m_exc[b] = ($urandom_range(0, 9) == 0);
      cp0_status      = $urandom;
      cp0_epc         = $urandom;
      mem_outstanding = $urandom_range(0, 1);
      redirect_ready  = $urandom_range(0, 1);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
